ir_fetch_unit: RTL and testbench

Two-byte instruction fetch sequencer for the 8-bit datapath. It drives the program counter onto the memory address bus and issues two reads: the low byte at PC and the high byte at PC+1. It steers each byte into the `ir` block through its `enable`/`funsel`/`lh` controls and keeps a shadow copy of the 16-bit instruction. It then hands the instruction to the downstream decode/control logic over a valid/ready handshake and supports a redirect of the next fetch address.

---
 rtl/ir_fetch_unit_if.sv | 36 +++
 rtl/ir_fetch_unit.sv | 135 +++++++++++++
 tb/tb_ir_fetch_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ir_fetch_unit_if.sv
// Bundle of fetch-unit signals: memory bus, ir block controls, decode handshake.
// Latency: none, wires only.
// Backpressure: carries instr_valid/instr_ready between the fetch unit and decode.
interface ir_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [7:0]        mem_data;
    logic              instr_ready;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_cs;
    logic              mem_wr;
    logic              ir_enable;
    logic [1:0]        ir_funsel;
    logic              ir_lh;
    logic [15:0]       instr;
    logic              instr_valid;
    logic              busy;
    logic [7:0]        fetch_count;

    // Fetch unit side
    modport master (
        input  start, mem_data, instr_ready, branch_en, branch_addr,
        output mem_addr, mem_cs, mem_wr, ir_enable, ir_funsel, ir_lh,
               instr, instr_valid, busy, fetch_count
    );

    // Memory / decode side
    modport slave (
        output start, mem_data, instr_ready, branch_en, branch_addr,
        input  mem_addr, mem_cs, mem_wr, ir_enable, ir_funsel, ir_lh,
               instr, instr_valid, busy, fetch_count
    );
endinterface

// File: rtl/ir_fetch_unit.sv
// Two-byte instruction fetch sequencer: reads PC and PC+1, steers bytes into ir, holds a shadow copy.
// Latency: start in IDLE -> instr_valid 3 cycles later; one instruction per 3 cycles back-to-back.
// Backpressure: instruction held in HOLD until instr_ready; optional counter under IR_FETCH_COUNT_EN.
module ir_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    ir_fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc_d;
    logic [15:0]       instr_q;
    logic              mem_cs_q;
    logic              ir_enable_q;
    logic [1:0]        ir_funsel_q;
    logic              ir_lh_q;
    logic              instr_valid_q;
    logic              busy_q;

    // PC arithmetic wraps naturally at 2^ADDR_W
    assign pc_inc_d = pc_q + PC_ONE;

    // Sequencer: state, PC, shadow instruction and registered strobes advance together
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 16'h0000;
            mem_cs_q      <= 1'b1;
            ir_enable_q   <= 1'b0;
            ir_funsel_q   <= 2'b00;
            ir_lh_q       <= 1'b0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q     <= FETCH_LO;
                        mem_cs_q    <= 1'b0;
                        ir_enable_q <= 1'b1;
                        ir_funsel_q <= 2'b01;
                        ir_lh_q     <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                FETCH_LO: begin
                    instr_q[7:0] <= bus.mem_data;
                    pc_q         <= pc_inc_d;
                    state_q      <= FETCH_HI;
                    ir_lh_q      <= 1'b1;
                end
                FETCH_HI: begin
                    instr_q[15:8] <= bus.mem_data;
                    pc_q          <= pc_inc_d;
                    state_q       <= HOLD;
                    mem_cs_q      <= 1'b1;
                    ir_enable_q   <= 1'b0;
                    ir_funsel_q   <= 2'b00;
                    ir_lh_q       <= 1'b0;
                    instr_valid_q <= 1'b1;
                end
                HOLD: begin
                    if (bus.instr_ready) begin
                        // Redirect only takes effect on an accepted handshake
                        if (bus.branch_en) begin
                            pc_q <= bus.branch_addr;
                        end
                        instr_valid_q <= 1'b0;
                        if (bus.start) begin
                            state_q     <= FETCH_LO;
                            mem_cs_q    <= 1'b0;
                            ir_enable_q <= 1'b1;
                            ir_funsel_q <= 2'b01;
                            ir_lh_q     <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    mem_cs_q      <= 1'b1;
                    ir_enable_q   <= 1'b0;
                    ir_funsel_q   <= 2'b00;
                    ir_lh_q       <= 1'b0;
                    instr_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

`ifdef IR_FETCH_COUNT_EN
    logic [7:0] fetch_count_q;

    // Count completed instructions: one per exit from FETCH_HI
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 8'h00;
        end else if (state_q == FETCH_HI) begin
            fetch_count_q <= fetch_count_q + 8'h01;
        end
    end

    assign bus.fetch_count = fetch_count_q;
`else
    assign bus.fetch_count = 8'h00;
`endif

    assign bus.mem_addr    = pc_q;
    assign bus.mem_cs      = mem_cs_q;
    assign bus.mem_wr      = 1'b0;
    assign bus.ir_enable   = ir_enable_q;
    assign bus.ir_funsel   = ir_funsel_q;
    assign bus.ir_lh       = ir_lh_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Bench for ir_fetch_unit: directed scenarios plus randomized stalls/redirects against a byte-level model.
// Latency: checks every fetch cycle at the exact expected cycle.
// Backpressure: exercises HOLD stalls and handshake-time redirects.
module tb_ir_fetch_unit;

    logic clk;
    logic reset;
    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    // Reference model state: where the next fetch reads, what was last fetched, how many completed
    logic [7:0]  m_pc;
    logic [15:0] m_instr;
    logic [7:0]  m_count;

    ir_fetch_unit_if #(.ADDR_W(8)) bus ();

    ir_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mem_data = mem[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_fc();
`ifdef IR_FETCH_COUNT_EN
        return m_count;
`else
        return 8'h00;
`endif
    endfunction

    task automatic rand_ignored_inputs();
        bus.start       = 1'($urandom_range(0, 1));
        bus.branch_en   = 1'($urandom_range(0, 1));
        bus.branch_addr = 8'($urandom);
        bus.instr_ready = 1'($urandom_range(0, 1));
    endtask

    // Caller has arranged that the next rising edge enters FETCH_LO
    task automatic fetch_and_check();
        logic [7:0] pc0;
        logic [7:0] pc1;
        pc0 = m_pc;
        pc1 = pc0 + 8'd1;
        @(negedge clk);
        chk("lo_addr",   16'(bus.mem_addr), 16'(pc0));
        chk("lo_cs",     16'(bus.mem_cs), 16'd0);
        chk("lo_en",     16'(bus.ir_enable), 16'd1);
        chk("lo_funsel", 16'(bus.ir_funsel), 16'd1);
        chk("lo_lh",     16'(bus.ir_lh), 16'd0);
        chk("lo_busy",   16'(bus.busy), 16'd1);
        chk("lo_valid",  16'(bus.instr_valid), 16'd0);
        chk("lo_wr",     16'(bus.mem_wr), 16'd0);
        rand_ignored_inputs();
        @(negedge clk);
        chk("hi_addr",   16'(bus.mem_addr), 16'(pc1));
        chk("hi_cs",     16'(bus.mem_cs), 16'd0);
        chk("hi_en",     16'(bus.ir_enable), 16'd1);
        chk("hi_funsel", 16'(bus.ir_funsel), 16'd1);
        chk("hi_lh",     16'(bus.ir_lh), 16'd1);
        chk("hi_lobyte", 16'(bus.instr[7:0]), 16'(mem[pc0]));
        chk("hi_valid",  16'(bus.instr_valid), 16'd0);
        rand_ignored_inputs();
        m_instr = {mem[pc1], mem[pc0]};
        m_pc    = pc1 + 8'd1;
        m_count = m_count + 8'd1;
        @(negedge clk);
        chk("hold_valid",  16'(bus.instr_valid), 16'd1);
        chk("hold_instr",  bus.instr, m_instr);
        chk("hold_addr",   16'(bus.mem_addr), 16'(m_pc));
        chk("hold_cs",     16'(bus.mem_cs), 16'd1);
        chk("hold_en",     16'(bus.ir_enable), 16'd0);
        chk("hold_funsel", 16'(bus.ir_funsel), 16'd0);
        chk("hold_busy",   16'(bus.busy), 16'd1);
        chk("hold_fcnt",   16'(bus.fetch_count), 16'(exp_fc()));
        bus.instr_ready = 1'b0;
        bus.branch_en   = 1'b0;
    endtask

    // Stay in HOLD for n cycles with instr_ready low; start/branch wiggle freely
    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            bus.instr_ready = 1'b0;
            bus.start       = 1'($urandom_range(0, 1));
            bus.branch_en   = 1'($urandom_range(0, 1));
            bus.branch_addr = 8'($urandom);
            @(negedge clk);
            chk("stall_valid", 16'(bus.instr_valid), 16'd1);
            chk("stall_instr", bus.instr, m_instr);
            chk("stall_addr",  16'(bus.mem_addr), 16'(m_pc));
            chk("stall_cs",    16'(bus.mem_cs), 16'd1);
            chk("stall_en",    16'(bus.ir_enable), 16'd0);
        end
        bus.branch_en = 1'b0;
    endtask

    // Called from HOLD: accept the instruction, optionally redirect, then fetch or go idle
    task automatic handshake(input logic br, input logic [7:0] addr, input logic st);
        bus.instr_ready = 1'b1;
        bus.branch_en   = br;
        bus.branch_addr = addr;
        bus.start       = st;
        if (br) m_pc = addr;
        if (st) begin
            fetch_and_check();
        end else begin
            @(negedge clk);
            bus.instr_ready = 1'b0;
            bus.branch_en   = 1'b0;
            chk("idle_busy",  16'(bus.busy), 16'd0);
            chk("idle_valid", 16'(bus.instr_valid), 16'd0);
            chk("idle_cs",    16'(bus.mem_cs), 16'd1);
            chk("idle_en",    16'(bus.ir_enable), 16'd0);
            chk("idle_addr",  16'(bus.mem_addr), 16'(m_pc));
            chk("idle_instr", bus.instr, m_instr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'h95;
        mem[8'h11] = 8'h01;
        mem[8'hFF] = 8'hAA;
        mem[8'h00] = 8'h55;

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.instr_ready = 1'b0;
        bus.branch_en   = 1'b0;
        bus.branch_addr = 8'h00;
        m_pc    = 8'h00;
        m_instr = 16'h0000;
        m_count = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr",   16'(bus.mem_addr), 16'h0000);
        chk("rst_cs",     16'(bus.mem_cs), 16'd1);
        chk("rst_wr",     16'(bus.mem_wr), 16'd0);
        chk("rst_en",     16'(bus.ir_enable), 16'd0);
        chk("rst_funsel", 16'(bus.ir_funsel), 16'd0);
        chk("rst_lh",     16'(bus.ir_lh), 16'd0);
        chk("rst_instr",  bus.instr, 16'h0000);
        chk("rst_valid",  16'(bus.instr_valid), 16'd0);
        chk("rst_busy",   16'(bus.busy), 16'd0);
        chk("rst_fcnt",   16'(bus.fetch_count), 16'd0);
        reset = 1'b0;

        // Start held low: must stay idle
        @(negedge clk);
        chk("idle_hold_busy", 16'(bus.busy), 16'd0);
        chk("idle_hold_cs",   16'(bus.mem_cs), 16'd1);

        // First fetch from reset PC, then redirect to 0x10
        bus.start = 1'b1;
        fetch_and_check();
        handshake(1'b1, 8'h10, 1'b1);
        chk("tp_instr_0195", bus.instr, 16'h0195);
        chk("tp_addr_12",    16'(bus.mem_addr), 16'h0012);

        // Stall then resume sequentially at 0x12
        stall(5);
        handshake(1'b0, 8'h00, 1'b1);

        // Redirect to 0x40, then to 0xFF for an instruction straddling the wrap
        handshake(1'b1, 8'h40, 1'b1);
        handshake(1'b1, 8'hFF, 1'b1);
        chk("wrap_instr", bus.instr, 16'h55AA);
        chk("wrap_addr",  16'(bus.mem_addr), 16'h0001);

        // Randomized stalls and redirects
        for (int k = 0; k < 8; k++) begin
            stall($urandom_range(0, 3));
            handshake(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
        end

        // Handshake with start low returns to idle
        bus.start = 1'b0;
        handshake(1'b0, 8'h00, 1'b0);

        // Reset during FETCH_HI discards the partial instruction
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("pre_rst_lh", 16'(bus.ir_lh), 16'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_instr", bus.instr, 16'h0000);
        chk("mid_rst_addr",  16'(bus.mem_addr), 16'h0000);
        chk("mid_rst_valid", 16'(bus.instr_valid), 16'd0);
        chk("mid_rst_busy",  16'(bus.busy), 16'd0);
        chk("mid_rst_cs",    16'(bus.mem_cs), 16'd1);
        chk("mid_rst_en",    16'(bus.ir_enable), 16'd0);
        chk("mid_rst_fcnt",  16'(bus.fetch_count), 16'd0);
        reset   = 1'b0;
        m_pc    = 8'h00;
        m_instr = 16'h0000;
        m_count = 8'h00;

        // Three back-to-back fetches after reset
        bus.start = 1'b1;
        fetch_and_check();
        handshake(1'b0, 8'h00, 1'b1);
        handshake(1'b0, 8'h00, 1'b1);
`ifdef IR_FETCH_COUNT_EN
        chk("fcnt_three", 16'(bus.fetch_count), 16'd3);
`else
        chk("fcnt_three", 16'(bus.fetch_count), 16'd0);
`endif
        bus.start = 1'b0;
        handshake(1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
